// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle ARM sequencer: FSM states, instruction
// classes and register-file write-back source selects.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_SDT = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_UND = 2'b11;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SEL_BASE = 2'b11;

    // Timeout counter width; covers the full 1..255 MEM_TIMEOUT range.
    localparam int TMO_W = 8;

endpackage

// File: rtl/multicycle_controller_if.sv
// Data-memory request/acknowledge handshake between the sequencer (master)
// and the data memory (slave).
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/multicycle_controller_timeout.sv
// Memory-wait timeout counter: counts enabled cycles and flags the cycle in
// which the count would reach MEM_TIMEOUT.
module ctrl_timeout_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // High during the MEM_TIMEOUT-th enabled cycle, so the abort happens in that cycle.
    assign tc = en && (cnt == TMO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Five-stage multi-cycle sequencer for the ARM datapath. Optional performance
// counters are built when CTRL_PERF_EN is defined.
//   state     | meaning
//   FETCH     | latch instruction register
//   DECODE    | condition check, undefined-instruction trap
//   EXECUTE   | ALU operation, branch / link write
//   MEMORY    | data-memory access with timeout
//   WRITEBACK | register-file write (two cycles for load with base write-back)
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
`ifdef CTRL_PERF_EN
    , parameter int CNT_W = 32
`endif
)(
    input  logic                clk,
    input  logic                nreset,
    input  logic [1:0]          instr_class,
    input  logic                cond_pass,
    input  logic                s_bit,
    input  logic                rd_write,
    input  logic                rd_is_pc,
    input  logic                load_bit,
    input  logic                wb_bit,
    input  logic                link_bit,
    multicycle_controller_if.master mem,
    output logic [2:0]          state,
    output logic                ir_write,
    output logic                pc_inc,
    output logic                pc_branch,
    output logic                alu_en,
    output logic                cpsr_write,
    output logic                rf_write_en,
    output logic [1:0]          rf_wb_sel,
    output logic                undef_err,
    output logic                mem_err
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic [CNT_W-1:0]    skipped_cnt,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);
    state_t     state_q;
    logic [1:0] cls_q;
    logic       rd_write_q;
    logic       rd_is_pc_q;
    logic       load_q;
    logic       wb_q;
    logic       wb_pend_q;
    logic       pc_inc_q;
    logic       pc_inc_now;
    logic       mem_req_q;
    logic       mem_we_q;
    logic       tmo_en;
    logic       tmo_clr;
    logic       tmo_tc;

    assign tmo_en  = (state_q == ST_MEMORY);
    assign tmo_clr = (state_q != ST_MEMORY) || mem.mem_ack;

    ctrl_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .clk (clk),
        .rst (nreset),
        .clr (tmo_clr),
        .en  (tmo_en),
        .tc  (tmo_tc)
    );

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q     <= ST_FETCH;
            cls_q       <= CLS_DP;
            rd_write_q  <= 1'b0;
            rd_is_pc_q  <= 1'b0;
            load_q      <= 1'b0;
            wb_q        <= 1'b0;
            wb_pend_q   <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_branch   <= 1'b0;
            alu_en      <= 1'b0;
            cpsr_write  <= 1'b0;
            rf_write_en <= 1'b0;
            rf_wb_sel   <= SEL_ALU;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            undef_err   <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            pc_inc_q    <= 1'b0;
            pc_branch   <= 1'b0;
            alu_en      <= 1'b0;
            cpsr_write  <= 1'b0;
            rf_write_en <= 1'b0;
            rf_wb_sel   <= SEL_ALU;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (!cond_pass) begin
                        state_q <= ST_FETCH;
                    end else if (instr_class == CLS_UND) begin
                        undef_err <= 1'b1;
                        state_q   <= ST_FETCH;
                    end else begin
                        state_q    <= ST_EXECUTE;
                        cls_q      <= instr_class;
                        rd_write_q <= rd_write;
                        rd_is_pc_q <= rd_is_pc;
                        load_q     <= load_bit;
                        wb_q       <= wb_bit;
                        alu_en     <= 1'b1;
                        if (instr_class == CLS_DP) begin
                            cpsr_write <= s_bit;
                            pc_inc_q   <= !rd_write;
                        end else if (instr_class == CLS_BR) begin
                            pc_branch   <= 1'b1;
                            rf_write_en <= link_bit;
                            rf_wb_sel   <= link_bit ? SEL_LINK : SEL_ALU;
                        end
                    end
                end
                ST_EXECUTE: begin
                    if (cls_q == CLS_SDT) begin
                        state_q   <= ST_MEMORY;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= !load_q;
                    end else if (cls_q == CLS_DP && rd_write_q) begin
                        state_q     <= ST_WRITEBACK;
                        rf_write_en <= 1'b1;
                        rf_wb_sel   <= SEL_ALU;
                        pc_inc_q    <= !rd_is_pc_q;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_MEMORY: begin
                    if (mem.mem_ack) begin
                        if (load_q) begin
                            state_q     <= ST_WRITEBACK;
                            rf_write_en <= 1'b1;
                            rf_wb_sel   <= SEL_MEM;
                            pc_inc_q    <= !wb_q && !rd_is_pc_q;
                            wb_pend_q   <= wb_q;
                        end else if (wb_q) begin
                            state_q     <= ST_WRITEBACK;
                            rf_write_en <= 1'b1;
                            rf_wb_sel   <= SEL_BASE;
                            pc_inc_q    <= !rd_is_pc_q;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end else if (tmo_tc) begin
                        mem_err <= 1'b1;
                        state_q <= ST_FETCH;
                    end else begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= !load_q;
                    end
                end
                ST_WRITEBACK: begin
                    wb_pend_q <= 1'b0;
                    if (wb_pend_q) begin
                        rf_write_en <= 1'b1;
                        rf_wb_sel   <= SEL_BASE;
                        pc_inc_q    <= !rd_is_pc_q;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Exits decided by same-cycle cond_pass or mem_ack/timeout need the PC pulse in that cycle.
    assign pc_inc_now = (state_q == ST_DECODE && (!cond_pass || instr_class == CLS_UND))
                     || (state_q == ST_MEMORY && ((mem.mem_ack && !load_q && !wb_q)
                                                 || (!mem.mem_ack && tmo_tc)));

    assign pc_inc      = pc_inc_q || pc_inc_now;
    assign ir_write    = (state_q == ST_FETCH);
    assign state       = state_q;
    assign mem.mem_req = mem_req_q;
    assign mem.mem_we  = mem_we_q;

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (nreset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            skipped_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if ((pc_inc || pc_branch) && state_q != ST_DECODE)
                retired_cnt <= retired_cnt + 1'b1;
            if (state_q == ST_DECODE && !cond_pass)
                skipped_cnt <= skipped_cnt + 1'b1;
            if (state_q == ST_MEMORY && !mem.mem_ack)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction expected cycle
// traces are queued from a spec-level model and compared cycle by cycle.
module tb_multicycle_controller;
    import cpu_ctrl_pkg::*;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic [1:0] instr_class = 2'b00;
    logic       cond_pass = 1'b0, s_bit = 1'b0, rd_write = 1'b0, rd_is_pc = 1'b0;
    logic       load_bit = 1'b0, wb_bit = 1'b0, link_bit = 1'b0;
    logic [2:0] state;
    logic       ir_write, pc_inc, pc_branch, alu_en, cpsr_write, rf_write_en;
    logic       undef_err, mem_err;
    logic [1:0] rf_wb_sel;

    multicycle_controller_if mem ();
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt, skipped_cnt, stall_cnt;
    logic [31:0] stall0;
`endif

    multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .instr_class (instr_class),
        .cond_pass   (cond_pass),
        .s_bit       (s_bit),
        .rd_write    (rd_write),
        .rd_is_pc    (rd_is_pc),
        .load_bit    (load_bit),
        .wb_bit      (wb_bit),
        .link_bit    (link_bit),
        .mem         (mem),
        .state       (state),
        .ir_write    (ir_write),
        .pc_inc      (pc_inc),
        .pc_branch   (pc_branch),
        .alu_en      (alu_en),
        .cpsr_write  (cpsr_write),
        .rf_write_en (rf_write_en),
        .rf_wb_sel   (rf_wb_sel),
        .undef_err   (undef_err),
        .mem_err     (mem_err)
`ifdef CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt),
        .skipped_cnt (skipped_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // v = {state, ir, pc_inc, pc_branch, alu, cpsr, rf_we, sel[1:0], mem_req, mem_we, undef_err, mem_err}
    typedef struct packed {
        logic        ack;
        logic [14:0] v;
    } rec_t;

    rec_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic exp_uerr = 1'b0;
    logic exp_merr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic ack, input logic [2:0] st, input logic ir, input logic pi,
                        input logic pb, input logic alu, input logic cpsr, input logic rfw,
                        input logic [1:0] sel, input logic mreq, input logic mwe);
        rec_t r;
        r.ack = ack;
        r.v   = {st, ir, pi, pb, alu, cpsr, rfw, sel, mreq, mwe, exp_uerr, exp_merr};
        q.push_back(r);
    endtask

    // ack_at: MEMORY cycle (1-based) carrying mem_ack, 0 = never; mem_limit: stop trace after N MEMORY cycles.
    task automatic run_instr(input string name, input logic [1:0] cls, input logic cp, input logic s,
                             input logic rdw, input logic rdpc, input logic ld, input logic wb,
                             input logic lk, input int ack_at, input int mem_limit, input logic noise);
        rec_t        r;
        logic [14:0] obs;
        logic        acked;
        int          cyc;
        push(noise, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b0, 1'b0);
        push(noise, ST_DECODE, 1'b0, !cp || cls == CLS_UND, 1'b0, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b0, 1'b0);
        if (cp && cls == CLS_UND) begin
            exp_uerr = 1'b1;
        end else if (cp && cls == CLS_DP) begin
            push(noise, ST_EXECUTE, 1'b0, !rdw, 1'b0, 1'b1, s, 1'b0, SEL_ALU, 1'b0, 1'b0);
            if (rdw) push(noise, ST_WRITEBACK, 1'b0, !rdpc, 1'b0, 1'b0, 1'b0, 1'b1, SEL_ALU, 1'b0, 1'b0);
        end else if (cp && cls == CLS_BR) begin
            push(noise, ST_EXECUTE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, lk, lk ? SEL_LINK : SEL_ALU, 1'b0, 1'b0);
        end else if (cp) begin
            push(noise, ST_EXECUTE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SEL_ALU, 1'b0, 1'b0);
            acked = 1'b0;
            for (int k = 1; k <= TMO; k++) begin
                if (mem_limit != 0 && k > mem_limit) break;
                if (k == ack_at) begin
                    push(1'b1, ST_MEMORY, 1'b0, !ld && !wb, 1'b0, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b1, !ld);
                    acked = 1'b1;
                    break;
                end
                if (k == TMO) begin
                    push(1'b0, ST_MEMORY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b1, !ld);
                    exp_merr = 1'b1;
                    break;
                end
                push(1'b0, ST_MEMORY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b1, !ld);
            end
            if (acked && ld) begin
                push(noise, ST_WRITEBACK, 1'b0, !wb && !rdpc, 1'b0, 1'b0, 1'b0, 1'b1, SEL_MEM, 1'b0, 1'b0);
                if (wb) push(noise, ST_WRITEBACK, 1'b0, !rdpc, 1'b0, 1'b0, 1'b0, 1'b1, SEL_BASE, 1'b0, 1'b0);
            end else if (acked && wb) begin
                push(noise, ST_WRITEBACK, 1'b0, !rdpc, 1'b0, 1'b0, 1'b0, 1'b1, SEL_BASE, 1'b0, 1'b0);
            end
        end
        cyc = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            if (cyc == 0) begin
                instr_class = cls; cond_pass = cp; s_bit = s; rd_write = rdw;
                rd_is_pc = rdpc; load_bit = ld; wb_bit = wb; link_bit = lk;
            end
            mem.mem_ack = r.ack;
            #1;
            obs = {state, ir_write, pc_inc, pc_branch, alu_en, cpsr_write, rf_write_en,
                   rf_wb_sel, mem.mem_req, mem.mem_we, undef_err, mem_err};
            tests++;
            assert (obs === r.v) else begin
                fails++;
                $error("FAIL %s cycle %0d observed=%h expected=%h", name, cyc, obs, r.v);
            end
            cyc++;
        end
    endtask

    initial begin
        mem.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",   32'(state), 32'd0);
        chk("rst_pc_inc",  32'(pc_inc), 32'd0);
        chk("rst_pc_br",   32'(pc_branch), 32'd0);
        chk("rst_alu_en",  32'(alu_en), 32'd0);
        chk("rst_rf_we",   32'(rf_write_en), 32'd0);
        chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
        chk("rst_undef",   32'(undef_err), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        nreset = 1'b0;

        //        name           cls      cp    s     rdw   rdpc  ld    wb    lk    ack lim noise
        run_instr("dp_add",      CLS_DP,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);
        run_instr("dp_cmp_ackx", CLS_DP,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b1);
        run_instr("skip_sdt",    CLS_SDT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,  0, 1'b0);
        run_instr("skip_und",    CLS_UND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);
`ifdef CTRL_PERF_EN
        stall0 = stall_cnt;
`endif
        run_instr("ldr_wait3",   CLS_SDT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4,  0, 1'b0);
`ifdef CTRL_PERF_EN
        chk("perf_stall", stall_cnt - stall0, 32'd3);
`endif
        run_instr("ldr_wb",      CLS_SDT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1,  0, 1'b0);
        run_instr("str",         CLS_SDT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2,  0, 1'b0);
        run_instr("str_wb",      CLS_SDT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1,  0, 1'b0);
        run_instr("bl",          CLS_BR,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0, 1'b0);
        run_instr("b",           CLS_BR,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);
        run_instr("dp_rd_pc",    CLS_DP,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);
        run_instr("str_ack_tmo", CLS_SDT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0, 1'b0);
        run_instr("undef",       CLS_UND, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);
        run_instr("str_timeout", CLS_SDT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);
        run_instr("dp_sticky",   CLS_DP,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);
        run_instr("ldr_pre_rst", CLS_SDT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,  3, 1'b0);

        nreset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_state",   32'(state), 32'd0);
        chk("mrst_mem_req", 32'(mem.mem_req), 32'd0);
        chk("mrst_undef",   32'(undef_err), 32'd0);
        chk("mrst_mem_err", 32'(mem_err), 32'd0);
        chk("mrst_rf_we",   32'(rf_write_en), 32'd0);
        nreset   = 1'b0;
        exp_uerr = 1'b0;
        exp_merr = 1'b0;
        run_instr("dp_post_rst", CLS_DP,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
